bram_tdp_cnt_ctrl: RTL and testbench

//  Counter-accumulator engine that drives one 1-clock true-dual-port BRAM (DEP x DAT) as a

---
 rtl/bram_tdp_cnt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bram_tdp_cnt_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_cnt_ctrl.sv
// Counter-accumulator controller for a 1-clock true-dual-port BRAM statistics store.
// Port A reads counters, port B writes them back. Increments and CPU read/read-clear
// share one issue slot per cycle. A short write history forwards results that the RAM
// read cannot see yet. Port B is driven in the result cycle, so its outputs are decoded
// from registered pipeline state and the RAM read data.
module bram_tdp_cnt_ctrl #(
    parameter int unsigned ADR = 10,
    parameter int unsigned DAT = 18,
    parameter int unsigned DEP = 1024,
    parameter int unsigned DEL = 1,
    parameter int unsigned INC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init_req,
    output logic           init_busy,
    input  logic           inc_vld,
    input  logic [ADR-1:0] inc_adr,
    input  logic [INC-1:0] inc_val,
    input  logic           cpu_req,
    input  logic [ADR-1:0] cpu_adr,
    input  logic           cpu_clr,
    output logic           cpu_ack,
    output logic [DAT-1:0] cpu_rdat,
    output logic [ADR-1:0] ram_adra,
    output logic           ram_rena,
    input  logic [DAT-1:0] ram_rdaa,
    output logic [ADR-1:0] ram_adrb,
    output logic           ram_wenb,
    output logic [DAT-1:0] ram_wdab
);

    localparam int unsigned    SUMW     = DAT + 1;
    localparam logic [ADR-1:0] CLR_LAST = ADR'(DEP - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic           vld;
        logic           cpu;
        logic           clr;
        logic [ADR-1:0] adr;
        logic [INC-1:0] val;
    } op_t;

    typedef struct packed {
        logic           vld;
        logic [ADR-1:0] adr;
        logic [DAT-1:0] dat;
    } wr_t;

    state_t         st;
    op_t            pipe [DEL+1];
    wr_t            hist [DEL];
    logic           clr_wen;
    logic [ADR-1:0] clr_adr;
    logic           cpu_pend;

    op_t            iss;
    op_t            res;
    logic           acc_inc;
    logic           acc_cpu;
    logic [DAT-1:0] base;
    logic [SUMW-1:0] sum;
    logic [DAT-1:0] new_val;
    logic [DAT-1:0] res_wdat;
    logic           res_ack;

    // Issue arbitration: increments win, CPU only when idle and nothing of its own in flight
    always_comb begin
        acc_inc = 1'b0;
        acc_cpu = 1'b0;
        iss     = '0;
        if (st == S_RUN && !init_req) begin
            if (inc_vld)
                acc_inc = 1'b1;
            else if (cpu_req && !cpu_pend)
                acc_cpu = 1'b1;
        end
        if (acc_inc) begin
            iss.vld = 1'b1;
            iss.adr = inc_adr;
            iss.val = inc_val;
        end else if (acc_cpu) begin
            iss.vld = 1'b1;
            iss.cpu = 1'b1;
            iss.clr = cpu_clr;
            iss.adr = cpu_adr;
        end
    end

    // Result stage: forward newest matching write, then saturating add or CPU rewrite
    always_comb begin
        res  = pipe[DEL];
        base = ram_rdaa;
        for (int i = int'(DEL) - 1; i >= 0; i--) begin
            if (hist[i].vld && hist[i].adr == res.adr)
                base = hist[i].dat;
        end
        sum      = {1'b0, base} + SUMW'(res.val);
        new_val  = sum[DAT] ? '1 : sum[DAT-1:0];
        res_wdat = new_val;
        if (res.cpu)
            res_wdat = res.clr ? '0 : base;
        res_ack  = res.vld && res.cpu && !init_req;
    end

    assign ram_rena = pipe[0].vld;
    assign ram_adra = pipe[0].adr;
    assign ram_wenb = clr_wen | res.vld;
    assign ram_adrb = clr_wen ? clr_adr : (res.vld ? res.adr : '0);
    assign ram_wdab = clr_wen ? '0 : (res.vld ? res_wdat : '0);

    // Sequencer, op pipeline, write history and CPU response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            clr_wen   <= 1'b0;
            clr_adr   <= '0;
            init_busy <= 1'b0;
            cpu_pend  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdat  <= '0;
            for (int i = 0; i <= int'(DEL); i++)
                pipe[i] <= '0;
            for (int i = 0; i < int'(DEL); i++)
                hist[i] <= '0;
        end else begin
            pipe[0] <= iss;
            for (int i = 1; i <= int'(DEL); i++)
                pipe[i] <= init_req ? '0 : pipe[i-1];

            hist[0] <= init_req ? '0 : '{vld: ram_wenb, adr: ram_adrb, dat: ram_wdab};
            for (int i = 1; i < int'(DEL); i++)
                hist[i] <= init_req ? '0 : hist[i-1];

            cpu_ack <= res_ack;
            if (res_ack)
                cpu_rdat <= base;

            if (init_req || st != S_RUN)
                cpu_pend <= 1'b0;
            else if (acc_cpu)
                cpu_pend <= 1'b1;
            else if (cpu_ack)
                cpu_pend <= 1'b0;

            case (st)
                S_IDLE: begin
                    st        <= S_INIT;
                    clr_wen   <= 1'b1;
                    clr_adr   <= '0;
                    init_busy <= 1'b1;
                end
                S_INIT: begin
                    if (init_req) begin
                        clr_adr <= '0;
                    end else if (clr_adr == CLR_LAST) begin
                        st        <= S_RUN;
                        clr_wen   <= 1'b0;
                        clr_adr   <= '0;
                        init_busy <= 1'b0;
                    end else begin
                        clr_adr <= clr_adr + ADR'(1);
                    end
                end
                S_RUN: begin
                    if (init_req) begin
                        st        <= S_INIT;
                        clr_wen   <= 1'b1;
                        clr_adr   <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_tdp_cnt_ctrl.sv
// Directed bench: three controller instances (DEL=1/DAT=18/DEP=1024, DEL=2/DAT=18/DEP=16,
// DEL=1/DAT=8/DEP=16), each with a read-first behavioural TDP RAM.
module tb_bram_tdp_cnt_ctrl;

    localparam int NI = 3;

    logic clk;
    logic rst_n;

    logic       init_req [NI];
    logic       inc_vld  [NI];
    logic [9:0] inc_adr  [NI];
    logic [7:0] inc_val  [NI];
    logic       cpu_req  [NI];
    logic [9:0] cpu_adr  [NI];
    logic       cpu_clr  [NI];

    logic        busy_o [NI];
    logic        ack_o  [NI];
    logic [17:0] rdat_o [NI];
    logic        rena_o [NI];
    logic [9:0]  adra_o [NI];
    logic        wenb_o [NI];
    logic [9:0]  adrb_o [NI];
    logic [17:0] wdab_o [NI];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int unsigned DATK = (k == 2) ? 8 : 18;
        localparam int unsigned DELK = (k == 1) ? 2 : 1;
        localparam int unsigned DEPK = (k == 0) ? 1024 : 16;

        logic [DATK-1:0] rdat;
        logic [DATK-1:0] rdaa;
        logic [DATK-1:0] wdab;
        logic [9:0]      adra;
        logic [9:0]      adrb;
        logic            rena;
        logic            wenb;
        logic            ack;
        logic            busy;
        logic [DATK-1:0] mem  [1024];
        logic [DATK-1:0] rd_q [DELK];

        bram_tdp_cnt_ctrl #(
            .ADR(10), .DAT(DATK), .DEP(DEPK), .DEL(DELK), .INC(8)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .init_req (init_req[k]),
            .init_busy(busy),
            .inc_vld  (inc_vld[k]),
            .inc_adr  (inc_adr[k]),
            .inc_val  (inc_val[k]),
            .cpu_req  (cpu_req[k]),
            .cpu_adr  (cpu_adr[k]),
            .cpu_clr  (cpu_clr[k]),
            .cpu_ack  (ack),
            .cpu_rdat (rdat),
            .ram_adra (adra),
            .ram_rena (rena),
            .ram_rdaa (rdaa),
            .ram_adrb (adrb),
            .ram_wenb (wenb),
            .ram_wdab (wdab)
        );

        // Read-first RAM: a same-edge write is not visible to the read
        always @(posedge clk) begin
            if (rena)
                rd_q[0] <= mem[adra];
            for (int i = 1; i < int'(DELK); i++)
                rd_q[i] <= rd_q[i-1];
            if (wenb)
                mem[adrb] <= wdab;
        end
        assign rdaa = rd_q[DELK-1];

        assign busy_o[k] = busy;
        assign ack_o[k]  = ack;
        assign rdat_o[k] = 18'(rdat);
        assign rena_o[k] = rena;
        assign adra_o[k] = adra;
        assign wenb_o[k] = wenb;
        assign adrb_o[k] = adrb;
        assign wdab_o[k] = 18'(wdab);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic inc1(input int k, input int adr, input int val);
        inc_vld[k] = 1'b1;
        inc_adr[k] = 10'(adr);
        inc_val[k] = 8'(val);
        @(negedge clk);
        inc_vld[k] = 1'b0;
    endtask

    task automatic cpu_wait(input int k, output logic [17:0] rd, output int n);
        bit got = 1'b0;
        rd = '0;
        n  = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (ack_o[k]) begin
                got = 1'b1;
                rd  = rdat_o[k];
            end
        end
        cpu_req[k] = 1'b0;
        check($sformatf("ack_seen_k%0d", k), 32'(got), 32'd1);
    endtask

    task automatic cpu_read(input int k, input int adr, input logic clr,
                            output logic [17:0] rd, output int n);
        cpu_req[k] = 1'b1;
        cpu_adr[k] = 10'(adr);
        cpu_clr[k] = clr;
        cpu_wait(k, rd, n);
    endtask

    // Follows a clear sweep from its first busy cycle until init_busy falls
    task automatic sweep(input int k, output int busy_cnt, output int wr_ok, output int acks);
        busy_cnt = 0;
        wr_ok    = 0;
        acks     = 0;
        for (int j = 0; j < 1100; j++) begin
            if (!busy_o[k])
                break;
            busy_cnt++;
            if (wenb_o[k] && wdab_o[k] == 18'd0 && adrb_o[k] == 10'(busy_cnt - 1))
                wr_ok++;
            if (ack_o[k])
                acks++;
            if (j == 9)
                inc_vld[k] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [17:0] rd;
        int n;
        int bc;
        int wo;
        int ac;

        for (int k = 0; k < NI; k++) begin
            init_req[k] = 1'b0;
            inc_vld[k]  = 1'b0;
            inc_adr[k]  = '0;
            inc_val[k]  = '0;
            cpu_req[k]  = 1'b0;
            cpu_adr[k]  = '0;
            cpu_clr[k]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state: every output low
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_busy_k%0d", k), 32'(busy_o[k]), 32'd0);
            check($sformatf("rst_ack_k%0d", k),  32'(ack_o[k]),  32'd0);
            check($sformatf("rst_rdat_k%0d", k), 32'(rdat_o[k]), 32'd0);
            check($sformatf("rst_rena_k%0d", k), 32'(rena_o[k]), 32'd0);
            check($sformatf("rst_adra_k%0d", k), 32'(adra_o[k]), 32'd0);
            check($sformatf("rst_wenb_k%0d", k), 32'(wenb_o[k]), 32'd0);
            check($sformatf("rst_adrb_k%0d", k), 32'(adrb_o[k]), 32'd0);
            check($sformatf("rst_wdab_k%0d", k), 32'(wdab_o[k]), 32'd0);
        end

        // T1: post-reset sweep of 1024 zero writes, then a read of a cleared counter
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, bc, wo, ac);
        check("t1_busy_cycles", 32'(bc), 32'd1024);
        check("t1_clr_writes",  32'(wo), 32'd1024);
        check("t1_no_write_after", 32'(wenb_o[0]), 32'd0);
        cpu_read(0, 5, 1'b0, rd, n);
        check("t1_rdat", 32'(rd), 32'd0);
        check("t1_ack_latency", 32'(n), 32'd3);
        cpu_read(1, 5, 1'b0, rd, n);
        check("t1_rdat_del2", 32'(rd), 32'd0);
        check("t1_ack_latency_del2", 32'(n), 32'd4);

        // T2: four back-to-back increments of 3 to counter 7, read right behind them
        for (int k = 0; k < 2; k++) begin
            inc_vld[k] = 1'b1;
            inc_adr[k] = 10'd7;
            inc_val[k] = 8'd3;
            repeat (4) @(negedge clk);
            inc_vld[k] = 1'b0;
            cpu_read(k, 7, 1'b0, rd, n);
            check($sformatf("t2_fwd_k%0d", k), 32'(rd), 32'd12);
        end

        // T3: 255 to counter 3, one idle cycle, 255 again, then 255 to counter 4
        for (int k = 0; k < 2; k++) begin
            inc1(k, 3, 255);
            @(negedge clk);
            inc1(k, 3, 255);
            inc1(k, 4, 255);
            cpu_read(k, 3, 1'b0, rd, n);
            check($sformatf("t3_adr3_k%0d", k), 32'(rd), 32'd510);
            cpu_read(k, 4, 1'b0, rd, n);
            check($sformatf("t3_adr4_k%0d", k), 32'(rd), 32'd255);
        end

        // T4: 8-bit counters saturate at 255 and stay there
        inc1(2, 5, 200);
        inc1(2, 5, 100);
        cpu_read(2, 5, 1'b0, rd, n);
        check("t4_sat", 32'(rd), 32'd255);
        inc1(2, 5, 1);
        cpu_read(2, 5, 1'b0, rd, n);
        check("t4_sat_hold", 32'(rd), 32'd255);
        inc1(2, 6, 255);
        cpu_read(2, 6, 1'b1, rd, n);
        check("t4_exact_max", 32'(rd), 32'd255);
        cpu_read(2, 6, 1'b0, rd, n);
        check("t4_after_clr", 32'(rd), 32'd0);

        // T5: read-clear of counter 9 with an increment issued the cycle after accept
        inc1(0, 9, 40);
        cpu_req[0] = 1'b1;
        cpu_adr[0] = 10'd9;
        cpu_clr[0] = 1'b1;
        @(negedge clk);
        inc_vld[0] = 1'b1;
        inc_adr[0] = 10'd9;
        inc_val[0] = 8'd2;
        @(negedge clk);
        inc_vld[0] = 1'b0;
        cpu_wait(0, rd, n);
        check("t5_rdclr", 32'(rd), 32'd40);
        cpu_read(0, 9, 1'b0, rd, n);
        check("t5_after", 32'(rd), 32'd2);

        // T6: re-clear request while a CPU read is in flight and increments keep coming
        inc_vld[0] = 1'b1;
        inc_adr[0] = 10'd3;
        inc_val[0] = 8'd1;
        @(negedge clk);
        inc_vld[0] = 1'b0;
        cpu_req[0] = 1'b1;
        cpu_adr[0] = 10'd7;
        cpu_clr[0] = 1'b0;
        @(negedge clk);
        init_req[0] = 1'b1;
        inc_vld[0]  = 1'b1;
        inc_adr[0]  = 10'd7;
        inc_val[0]  = 8'd5;
        @(negedge clk);
        init_req[0] = 1'b0;
        check("t6_restart_adr", 32'(adrb_o[0]), 32'd0);
        check("t6_restart_wen", 32'(wenb_o[0]), 32'd1);
        sweep(0, bc, wo, ac);
        check("t6_busy_cycles", 32'(bc), 32'd1024);
        check("t6_clr_writes",  32'(wo), 32'd1024);
        check("t6_no_ack_in_init", 32'(ac), 32'd0);
        cpu_wait(0, rd, n);
        check("t6_held_req_rdat", 32'(rd), 32'd0);
        cpu_read(0, 3, 1'b0, rd, n);
        check("t6_adr3", 32'(rd), 32'd0);
        cpu_read(0, 4, 1'b0, rd, n);
        check("t6_adr4", 32'(rd), 32'd0);
        cpu_read(0, 9, 1'b0, rd, n);
        check("t6_adr9", 32'(rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
